tetris_playfield: RTL

//  Parametrised Tetris playfield engine: ROWS x COLS locked-cell grid, one falling piece
//  (7 tetrominoes + 2x4 bar), wall/stack collision, multi-line clear, line count, game over.

---
 rtl/tetris_playfield.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_playfield.sv
// Tetris playfield engine: ROWS x COLS locked grid, one falling piece, collision, line clear, game over.
// Define ROTATE_EN to enable clockwise rotation of the falling piece; rotation is ignored otherwise.

module tetris_playfield #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int DROP_DIV = 65536,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 move_left,
  input  logic                 move_right,
  input  logic                 rotate,
  input  logic [2:0]           piece_sel,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic [CNT_W-1:0]     lines_cleared,
  output logic                 game_over,
  output logic [2:0]           state
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(DROP_DIV);
  localparam int PW = $clog2(ROWS + COLS) + 3;

  localparam logic signed [PW-1:0] SPAWN_PC = PW'(COLS / 2 - 2);
  localparam logic signed [PW-1:0] ONE_P    = PW'(1);

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_LOCK  = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  // Piece masks are 4x4 boxes flattened row-major, bit 15 = box (0,0).
  function automatic logic [15:0] shape_mask(input logic [2:0] sel);
    case (sel)
      3'd0:    return 16'hF000;
      3'd1:    return 16'h6600;
      3'd2:    return 16'hE400;
      3'd3:    return 16'h6C00;
      3'd4:    return 16'hC600;
      3'd5:    return 16'h8E00;
      3'd6:    return 16'h2E00;
      default: return 16'hFF00;
    endcase
  endfunction

  function automatic logic collides(input logic [15:0] m, input int r0, input int c0,
                                    input grid_t g);
    int   r;
    int   c;
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = r0 + i;
        c = c0 + j;
        if (m[15 - (4 * i + j)]) begin
          if (c < 0 || c >= COLS || r >= ROWS) hit = 1'b1;
          else if (r >= 0 && g[r[RW-1:0]][c[CW-1:0]]) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic grid_t place(input logic [15:0] m, input int r0, input int c0);
    grid_t g;
    int    r;
    int    c;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r = r0 + i;
        c = c0 + j;
        if (m[15 - (4 * i + j)] && r >= 0 && r < ROWS && c >= 0 && c < COLS)
          g[r[RW-1:0]][c[CW-1:0]] = 1'b1;
      end
    end
    return g;
  endfunction

  state_t                 st;
  grid_t                  locked;
  logic [15:0]            mask;
  logic signed [PW-1:0]   pr;
  logic signed [PW-1:0]   pc;
  logic [RW-1:0]          scan;
  logic [DW-1:0]          drop_cnt;
  logic                   left_q;
  logic                   right_q;

  logic [15:0]            spawn_mask;
  grid_t                  active;
  logic                   hit_spawn;
  logic                   hit_down;
  logic                   hit_left;
  logic                   hit_right;
  logic                   drop_tick;
  logic                   left_edge;
  logic                   right_edge;
  logic                   show;
  logic [COLS-1:0][ROWS-1:0] grid_view;

  assign spawn_mask = shape_mask(piece_sel);
  assign hit_spawn  = collides(spawn_mask, 0, COLS / 2 - 2, locked);
  assign hit_down   = collides(mask, int'(pr) + 1, int'(pc), locked);
  assign hit_left   = collides(mask, int'(pr), int'(pc) - 1, locked);
  assign hit_right  = collides(mask, int'(pr), int'(pc) + 1, locked);
  assign active     = place(mask, int'(pr), int'(pc));
  assign drop_tick  = (drop_cnt == DW'(DROP_DIV - 1));
  assign left_edge  = move_left & ~left_q;
  assign right_edge = move_right & ~right_q;
  assign show       = (st == S_FALL) || (st == S_LOCK);
  assign state      = st;

`ifdef ROTATE_EN
  function automatic logic [15:0] rotate_cw(input logic [15:0] m);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[15 - (4 * j + 3 - i)] = m[15 - (4 * i + j)];
    return o;
  endfunction

  logic        rot_q;
  logic        rot_edge;
  logic        hit_rot;
  logic [15:0] rot_mask;

  assign rot_mask = rotate_cw(mask);
  assign rot_edge = rotate & ~rot_q;
  assign hit_rot  = collides(rot_mask, int'(pr), int'(pc), locked);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rot_q <= 1'b0;
    else        rot_q <= rotate;
  end
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grid_view = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        grid_view[c][r] = locked[r][c] | (show & active[r][c]);
  end

  // NOTE: the locked grid is read by collision logic from the first cycle, so it is reset like any register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= S_IDLE;
      locked        <= '0;
      mask          <= '0;
      pr            <= '0;
      pc            <= '0;
      scan          <= '0;
      drop_cnt      <= '0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
      grid_out      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
      left_q   <= move_left;
      right_q  <= move_right;
      grid_out <= grid_view;
      case (st)
        S_IDLE: begin
          locked        <= '0;
          lines_cleared <= '0;
          if (start) st <= S_SPAWN;
        end
        S_SPAWN: begin
          mask     <= spawn_mask;
          pr       <= '0;
          pc       <= SPAWN_PC;
          drop_cnt <= '0;
          if (hit_spawn) begin
            st        <= S_OVER;
            game_over <= 1'b1;
          end else begin
            st <= S_FALL;
          end
        end
        S_FALL: begin
          drop_cnt <= drop_tick ? '0 : drop_cnt + DW'(1);
          if (drop_tick) begin
            if (!hit_down) pr <= pr + ONE_P;
            else           st <= S_LOCK;
          end
`ifdef ROTATE_EN
          else if (rot_edge) begin
            if (!hit_rot) mask <= rot_mask;
          end
`endif
          else if (left_edge && !right_edge) begin
            if (!hit_left) pc <= pc - ONE_P;
          end else if (right_edge && !left_edge) begin
            if (!hit_right) pc <= pc + ONE_P;
          end
        end
        S_LOCK: begin
          locked <= locked | active;
          scan   <= RW'(ROWS - 1);
          st     <= S_CLEAR;
        end
        S_CLEAR: begin
          if (&locked[scan]) begin
            // Everything above the full row drops by one; the same index is re-tested next cycle.
            for (int r = 1; r < ROWS; r++)
              if (r <= int'(scan)) locked[r] <= locked[r-1];
            locked[0]     <= '0;
            lines_cleared <= lines_cleared + CNT_W'(1);
          end else if (scan == '0) begin
            st <= S_SPAWN;
          end else begin
            scan <= scan - RW'(1);
          end
        end
        S_OVER: begin
          if (start) begin
            st            <= S_IDLE;
            game_over     <= 1'b0;
            locked        <= '0;
            lines_cleared <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
